pulse_stretch_multi: RTL and testbench

//  Multi-channel, run-time programmable pulse stretcher; successor to the fixed 63-cycle single-channel extender.

---
 rtl/pulse_stretch_multi.sv | 123 ++++++++++++
 tb/tb_pulse_stretch_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_multi.sv
// Multi-channel programmable pulse stretcher: level/edge trigger, retriggerable or one-shot,
// optional hold-off, with a one-cycle flag for every ignored trigger.
module pulse_stretch_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [CNT_W-1:0]  stretch_len,
  input  logic [CNT_W-1:0]  holdoff_len,
  input  logic [NUM_CH-1:0] edge_mode,
  input  logic [NUM_CH-1:0] retrig_en,
  input  logic [NUM_CH-1:0] sync_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] missed
);

  typedef enum logic [1:0] {StIdle, StActive, StHoldoff} state_e;

  logic [NUM_CH-1:0] sync_in_q;
  logic [NUM_CH-1:0] trig;

  // History register runs regardless of en so edge detection is valid right after enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_in_q <= '0;
    end else begin
      sync_in_q <= sync_in;
    end
  end

  assign trig = (edge_mode & sync_in & ~sync_in_q) | (~edge_mode & sync_in);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] hold_q;
    logic             out_q;
    logic             busy_q;
    logic             miss_q;
    logic [CNT_W-1:0] len_last;

    // A latched length of 0 behaves as 1.
    assign len_last = (len_q == '0) ? '0 : len_q - CNT_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        len_q   <= '0;
        hold_q  <= '0;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
        miss_q  <= 1'b0;
      end else begin
        miss_q <= 1'b0;
        if (!en) begin
          state_q <= StIdle;
          cnt_q   <= '0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (trig[c]) begin
                state_q <= StActive;
                cnt_q   <= '0;
                len_q   <= stretch_len;
                out_q   <= 1'b1;
                busy_q  <= 1'b1;
              end
            end
            StActive: begin
              if (trig[c] && retrig_en[c]) begin
                cnt_q <= '0;
                len_q <= stretch_len;
              end else begin
                // An ignored one-shot trigger still lets the count run out.
                if (trig[c]) miss_q <= 1'b1;
                if (cnt_q == len_last) begin
                  out_q <= 1'b0;
                  cnt_q <= '0;
                  if (holdoff_len != '0) begin
                    state_q <= StHoldoff;
                    hold_q  <= holdoff_len;
                  end else begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                  end
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
            end
            StHoldoff: begin
              miss_q <= trig[c];
              if (cnt_q == hold_q - CNT_W'(1)) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            default: begin
              state_q <= StIdle;
              out_q   <= 1'b0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign sync_out[c] = out_q;
    assign busy[c]     = busy_q;
    assign missed[c]   = miss_q;
  end

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Bench for pulse_stretch_multi: table of per-cycle waveforms checked through a scoreboard,
// plus hand-written sequences for reset, enable, in-flight length change and async reset.
module tb_pulse_stretch_multi;
  localparam int NCH = 4;
  localparam int CW  = 6;
  localparam int NV  = 80;
  localparam int NREC = 9;

  logic           clk = 1'b0;
  logic           resetn;
  logic           en;
  logic [CW-1:0]  stretch_len;
  logic [CW-1:0]  holdoff_len;
  logic [NCH-1:0] edge_mode;
  logic [NCH-1:0] retrig_en;
  logic [NCH-1:0] sync_in;
  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] missed;

  pulse_stretch_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .stretch_len(stretch_len),
    .holdoff_len(holdoff_len),
    .edge_mode  (edge_mode),
    .retrig_en  (retrig_en),
    .sync_in    (sync_in),
    .sync_out   (sync_out),
    .busy       (busy),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  // Waveform bit j = level during cycle j; an input high in cycle t is sampled at edge t.
  typedef struct {
    logic [CW-1:0] slen;
    logic [CW-1:0] hlen;
    logic          edge_m;
    logic          retrig;
    int            stagger;
    logic [NV-1:0] in_v;
    logic [NV-1:0] out_v;
    logic [NV-1:0] busy_v;
    logic [NV-1:0] miss_v;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] out;
    logic [NCH-1:0] bsy;
    logic [NCH-1:0] mis;
  } exp_t;

  vec_t vecs[NREC];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [NV-1:0] win(int lo, int hi);
    logic [NV-1:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic bit_at(logic [NV-1:0] v, int idx);
    if (idx < 0 || idx >= NV) return 1'b0;
    return v[idx];
  endfunction

  task automatic check(string name, logic [NCH-1:0] act, logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_vec(int r, int slen, int hlen, logic em, logic rt, int stg,
                         logic [NV-1:0] iv, logic [NV-1:0] ov, logic [NV-1:0] bv,
                         logic [NV-1:0] mv);
    vecs[r].slen    = CW'(slen);
    vecs[r].hlen    = CW'(hlen);
    vecs[r].edge_m  = em;
    vecs[r].retrig  = rt;
    vecs[r].stagger = stg;
    vecs[r].in_v    = iv;
    vecs[r].out_v   = ov;
    vecs[r].busy_v  = bv;
    vecs[r].miss_v  = mv;
  endtask

  task automatic clean_start(int slen, int hlen, logic [NCH-1:0] em, logic [NCH-1:0] rt);
    @(negedge clk);
    en          = 1'b0;
    sync_in     = '0;
    stretch_len = CW'(slen);
    holdoff_len = CW'(hlen);
    edge_mode   = em;
    retrig_en   = rt;
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic run_vec(int r);
    exp_t e;
    exp_t got;
    clean_start(vecs[r].slen, vecs[r].hlen, {NCH{vecs[r].edge_m}}, {NCH{vecs[r].retrig}});
    for (int j = 0; j < NV - 1; j++) begin
      for (int c = 0; c < NCH; c++) begin
        sync_in[c] = bit_at(vecs[r].in_v, j - c * vecs[r].stagger);
        e.out[c]   = bit_at(vecs[r].out_v, j + 1 - c * vecs[r].stagger);
        e.bsy[c]   = bit_at(vecs[r].busy_v, j + 1 - c * vecs[r].stagger);
        e.mis[c]   = bit_at(vecs[r].miss_v, j + 1 - c * vecs[r].stagger);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check($sformatf("rec%0d cyc%0d sync_out", r, j + 1), sync_out, got.out);
      check($sformatf("rec%0d cyc%0d busy", r, j + 1), busy, got.bsy);
      check($sformatf("rec%0d cyc%0d missed", r, j + 1), missed, got.mis);
      @(negedge clk);
    end
  endtask

  initial begin
    int hi_cnt;

    // Default 63-cycle stretch.
    set_vec(0, 63, 0, 1'b0, 1'b0, 0, win(2, 2), win(3, 65), win(3, 65), '0);
    // Retrigger extends; one-shot flags the second pulse.
    set_vec(1, 8, 0, 1'b0, 1'b1, 0, win(2, 2) | win(7, 7), win(3, 15), win(3, 15), '0);
    set_vec(2, 8, 0, 1'b0, 1'b0, 0, win(2, 2) | win(7, 7), win(3, 10), win(3, 10), win(8, 8));
    // Hold-off: trigger inside dead time missed, next one accepted.
    set_vec(3, 4, 3, 1'b0, 1'b0, 0, win(2, 2) | win(8, 8) | win(10, 10),
            win(3, 6) | win(11, 14), win(3, 9) | win(11, 17), win(9, 9));
    // Held-high input: edge mode fires once; level retrig holds; level one-shot refires.
    set_vec(4, 4, 0, 1'b1, 1'b0, 0, win(2, 21), win(3, 6), win(3, 6), '0);
    set_vec(5, 4, 0, 1'b0, 1'b1, 0, win(2, 21), win(3, 25), win(3, 25), '0);
    set_vec(6, 4, 0, 1'b0, 1'b0, 0, win(2, 21),
            win(3, 6) | win(8, 11) | win(13, 16) | win(18, 21),
            win(3, 6) | win(8, 11) | win(13, 16) | win(18, 21),
            win(4, 7) | win(9, 12) | win(14, 17) | win(19, 22));
    // Zero length acts as one cycle.
    set_vec(7, 0, 0, 1'b0, 1'b0, 0, win(2, 2), win(3, 3), win(3, 3), '0);
    // Staggered channels stay independent.
    set_vec(8, 5, 2, 1'b0, 1'b0, 3, win(2, 2), win(3, 7), win(3, 9), '0);

    // Reset with inputs active, then first trigger after release.
    resetn      = 1'b0;
    en          = 1'b1;
    sync_in     = '1;
    stretch_len = CW'(4);
    holdoff_len = '0;
    edge_mode   = '0;
    retrig_en   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset sync_out", sync_out, '0);
    check("reset busy", busy, '0);
    check("reset missed", missed, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset sync_out", sync_out, '1);
    @(negedge clk);
    sync_in = '0;

    for (int r = 0; r < NREC; r++) run_vec(r);

    // Disable mid-pulse clears next cycle and ignores triggers without flagging.
    clean_start(20, 0, '0, '0);
    sync_in = 4'h1;
    @(negedge clk);
    sync_in = '0;
    repeat (4) @(negedge clk);
    check("en mid-pulse active", sync_out, 4'h1);
    en      = 1'b0;
    sync_in = '1;
    @(posedge clk);
    #1;
    check("en=0 sync_out", sync_out, '0);
    check("en=0 busy", busy, '0);
    check("en=0 missed", missed, '0);
    @(posedge clk);
    #1;
    check("en=0 trig ignored", sync_out | missed, '0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("re-enable level trig", sync_out, '1);
    @(negedge clk);
    sync_in = '0;

    // Length change while a pulse is in flight affects only the next pulse.
    clean_start(6, 0, '0, '0);
    sync_in = 4'h1;
    @(negedge clk);
    sync_in     = '0;
    stretch_len = CW'(2);
    hi_cnt      = 0;
    for (int i = 0; i < 20; i++) begin
      if (sync_out[0]) hi_cnt++;
      @(negedge clk);
    end
    check("inflight len kept", 4'(hi_cnt), 4'd6);
    sync_in = 4'h1;
    @(negedge clk);
    sync_in = '0;
    hi_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      if (sync_out[0]) hi_cnt++;
      @(negedge clk);
    end
    check("new len used", 4'(hi_cnt), 4'd2);

    // Asynchronous reset mid-pulse clears without a clock edge.
    clean_start(10, 0, '0, '0);
    sync_in = '1;
    @(negedge clk);
    sync_in = '0;
    repeat (3) @(negedge clk);
    check("pre-async-reset active", sync_out, '1);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset sync_out", sync_out, '0);
    check("async reset busy", busy, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("after async reset idle", sync_out | busy, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
